// File: rtl/if_id_reg.sv
// IF->ID pipeline register: captures the 1-cycle-latency instruction SRAM response,
// holds it across ID stalls and drops responses orphaned by a flush.
module if_id_reg #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_ID_reg_stall,
    input  logic        flush,
    input  logic        fetch_issued,
    input  logic        valid_IF,
    input  logic [31:0] pc_IF,
    input  logic        adel_IF,
    input  logic [31:0] inst_sram_rdata,
    output logic        if_allowin,
    output logic        valid_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] inst_ID,
    output logic        adel_ID
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        rdata_live_q;
    logic [31:0] hold_inst_q, hold_inst_d;

    logic        valid_id_q, valid_id_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic        adel_id_q, adel_id_d;

    logic [31:0] inst_if;
    logic        inst_ready;

    always_comb begin
        inst_if    = (state_q == HOLD) ? hold_inst_q : inst_sram_rdata;
        inst_ready = valid_IF & (adel_IF | (state_q == HOLD) |
                                 (rdata_live_q & (state_q != DISCARD)));
        if_allowin = (~IF_ID_reg_stall & (~valid_IF | inst_ready)) | flush;
    end

    // Hold/discard tracking: flush dominates stall; a flush that coincides with a
    // new read leaves that read's response to be dropped next cycle.
    always_comb begin
        state_d     = state_q;
        hold_inst_d = hold_inst_q;
        if (flush) begin
            state_d = fetch_issued ? DISCARD : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (IF_ID_reg_stall && valid_IF && rdata_live_q && !adel_IF) begin
                        state_d     = HOLD;
                        hold_inst_d = inst_sram_rdata;
                    end
                end
                HOLD: begin
                    if (!IF_ID_reg_stall) begin
                        state_d = IDLE;
                    end
                end
                DISCARD: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        valid_id_d = valid_id_q;
        pc_id_d    = pc_id_q;
        inst_id_d  = inst_id_q;
        adel_id_d  = adel_id_q;
        if (flush) begin
            valid_id_d = 1'b0;
        end else if (!IF_ID_reg_stall) begin
            valid_id_d = inst_ready;
            pc_id_d    = pc_IF;
            adel_id_d  = adel_IF;
            inst_id_d  = adel_IF ? 32'h0 : inst_if;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rdata_live_q <= 1'b0;
            valid_id_q   <= 1'b0;
            pc_id_q      <= RESET_PC;
            inst_id_q    <= 32'h0;
            adel_id_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdata_live_q <= fetch_issued;
            valid_id_q   <= valid_id_d;
            pc_id_q      <= pc_id_d;
            inst_id_q    <= inst_id_d;
            adel_id_q    <= adel_id_d;
        end
    end

    // Held word is pure data; its validity is carried by state_q.
    always_ff @(posedge clk) begin
        hold_inst_q <= hold_inst_d;
    end

    assign valid_ID = valid_id_q;
    assign pc_ID    = pc_id_q;
    assign inst_ID  = inst_id_q;
    assign adel_ID  = adel_id_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed vectors, a fetch-level reference model checked
// every cycle, and hand-computed literal expectations.
module tb_if_id_reg;

    localparam logic [31:0] RPC = 32'hbfc00000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, fi = 1'b0, vif = 1'b0, adel = 1'b0;
    logic [31:0] pc = 32'h0, rdata = 32'h0;
    logic        if_allowin, valid_ID, adel_ID;
    logic [31:0] pc_ID, inst_ID;

    if_id_reg #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .IF_ID_reg_stall(stall), .flush(flush),
        .fetch_issued(fi), .valid_IF(vif), .pc_IF(pc), .adel_IF(adel),
        .inst_sram_rdata(rdata), .if_allowin(if_allowin), .valid_ID(valid_ID),
        .pc_ID(pc_ID), .inst_ID(inst_ID), .adel_ID(adel_ID)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: what ID should hold, whether IF owns a captured word, and whether
    // the response arriving this cycle belongs to a fetch that was flushed.
    logic        m_valid, m_adel, m_known, m_held, m_pend, m_orph;
    logic [31:0] m_pc, m_inst, m_hw;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic m_ready();
        return vif & (adel | m_held | (m_pend & ~m_orph));
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_ID", {31'h0, valid_ID}, {31'h0, m_valid});
            chk("if_allowin", {31'h0, if_allowin}, {31'h0, (~stall & (~vif | m_ready())) | flush});
            if (m_known) begin
                chk("pc_ID", pc_ID, m_pc);
                chk("inst_ID", inst_ID, m_inst);
                chk("adel_ID", {31'h0, adel_ID}, {31'h0, m_adel});
            end
        end
    end

    task automatic cyc(input bit r, input bit st, input bit fl, input bit f, input bit v,
                       input logic [31:0] p, input bit a, input logic [31:0] d);
        logic        n_valid, n_adel, n_known, n_held, n_pend, n_orph, rdy;
        logic [31:0] n_pc, n_inst, n_hw, word;
        reset = r; stall = st; flush = fl; fi = f; vif = v; pc = p; adel = a; rdata = d;
        @(negedge clk);
        rdy  = m_ready();
        word = m_held ? m_hw : rdata;
        n_valid = m_valid; n_adel = m_adel; n_known = m_known; n_held = m_held;
        n_pc = m_pc; n_inst = m_inst; n_hw = m_hw;
        n_pend = f; n_orph = f & fl;
        if (r) begin
            n_valid = 1'b0; n_pc = RPC; n_inst = 32'h0; n_adel = 1'b0;
            n_held = 1'b0; n_known = 1'b1; n_pend = 1'b0; n_orph = 1'b0;
        end else if (fl) begin
            n_valid = 1'b0; n_held = 1'b0; n_known = 1'b0;
        end else if (st) begin
            if (!m_held && v && m_pend && !m_orph && !a) begin
                n_held = 1'b1; n_hw = d;
            end
        end else begin
            n_valid = rdy; n_pc = p; n_adel = a; n_inst = a ? 32'h0 : word;
            n_held = 1'b0; n_known = 1'b1;
        end
        @(posedge clk);
        m_valid = n_valid; m_adel = n_adel; m_known = n_known; m_held = n_held;
        m_pc = n_pc; m_inst = n_inst; m_hw = n_hw; m_pend = n_pend; m_orph = n_orph;
        if (r) chk_en = 1'b1;
        #1;
    endtask

    initial begin
        // reset
        cyc(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        chk("rst_valid", {31'h0, valid_ID}, 32'h0);
        chk("rst_pc", pc_ID, 32'hbfc00000);
        chk("rst_inst", inst_ID, 32'h0);
        chk("rst_adel", {31'h0, adel_ID}, 32'h0);
        chk("rst_allowin", {31'h0, if_allowin}, 32'h1);
        // first fetch, back-to-back with a second one
        cyc(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        cyc(0, 0, 0, 1, 1, 32'hbfc00000, 0, 32'h24020001);
        chk("t2_valid", {31'h0, valid_ID}, 32'h1);
        chk("t2_pc", pc_ID, 32'hbfc00000);
        chk("t2_inst", inst_ID, 32'h24020001);
        // stall while the second response is live; SRAM output then changes
        cyc(0, 1, 0, 0, 1, 32'hbfc00004, 0, 32'h8c430000);
        chk("t3_hold_inst", inst_ID, 32'h24020001);
        chk("t3_allowin", {31'h0, if_allowin}, 32'h0);
        cyc(0, 1, 0, 0, 1, 32'hbfc00004, 0, 32'hdeadbeef);
        cyc(0, 1, 0, 0, 1, 32'hbfc00004, 0, 32'hdeadbeef);
        chk("t3_hold_inst2", inst_ID, 32'h24020001);
        cyc(0, 0, 0, 0, 1, 32'hbfc00004, 0, 32'hdeadbeef);
        chk("t3_rel_valid", {31'h0, valid_ID}, 32'h1);
        chk("t3_rel_pc", pc_ID, 32'hbfc00004);
        chk("t3_rel_inst", inst_ID, 32'h8c430000);
        // flush with a fetch in flight: its response is orphaned
        cyc(0, 0, 1, 1, 1, 32'hbfc00008, 0, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'hbfc00380, 0, 32'h11111111);
        chk("t4_drop_valid", {31'h0, valid_ID}, 32'h0);
        cyc(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'hbfc00380, 0, 32'h22222222);
        chk("t4_valid", {31'h0, valid_ID}, 32'h1);
        chk("t4_inst", inst_ID, 32'h22222222);
        chk("t4_pc", pc_ID, 32'hbfc00380);
        // flush and stall together while holding a word
        cyc(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 0, 1, 32'hbfc00384, 0, 32'h33333333);
        cyc(0, 1, 1, 0, 1, 32'hbfc00384, 0, 32'h44444444);
        chk("t5_flush_valid", {31'h0, valid_ID}, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'hbfc00384, 0, 32'h33333333);
        chk("t5_nohold_valid", {31'h0, valid_ID}, 32'h0);
        // address error: no SRAM word needed, instruction forced to zero
        cyc(0, 0, 0, 0, 1, 32'hbfc00002, 1, 32'h55555555);
        chk("t6_adel_valid", {31'h0, valid_ID}, 32'h1);
        chk("t6_adel", {31'h0, adel_ID}, 32'h1);
        chk("t6_adel_inst", inst_ID, 32'h0);
        chk("t6_adel_pc", pc_ID, 32'hbfc00002);
        // reset while holding
        cyc(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        cyc(0, 1, 0, 0, 1, 32'hbfc00008, 0, 32'h66666666);
        cyc(1, 1, 0, 0, 1, 32'hbfc00008, 0, 32'h0);
        chk("t6_rst_valid", {31'h0, valid_ID}, 32'h0);
        chk("t6_rst_pc", pc_ID, 32'hbfc00000);
        cyc(0, 0, 0, 0, 1, 32'hbfc00008, 0, 32'h0);
        chk("t6_rst_nohold", {31'h0, valid_ID}, 32'h0);
        // flush on the live cycle without a new fetch
        cyc(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        cyc(0, 0, 1, 0, 1, 32'hbfc0000c, 0, 32'h77777777);
        cyc(0, 0, 0, 0, 1, 32'hbfc0000c, 0, 32'h77777777);
        chk("fl_live_valid", {31'h0, valid_ID}, 32'h0);
        // back-to-back flush+fetch keeps discarding
        cyc(0, 0, 1, 1, 0, 32'h0, 0, 32'h0);
        cyc(0, 0, 1, 1, 0, 32'h0, 0, 32'h99999999);
        cyc(0, 0, 0, 0, 1, 32'hbfc00010, 0, 32'h88888888);
        chk("disc2_valid", {31'h0, valid_ID}, 32'h0);
        cyc(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'hbfc00010, 0, 32'habcd0123);
        chk("disc2_new_valid", {31'h0, valid_ID}, 32'h1);
        chk("disc2_new_inst", inst_ID, 32'habcd0123);
        // stall with an address error does not capture a word
        cyc(0, 1, 0, 0, 1, 32'hbfc00012, 1, 32'h12345678);
        chk("st_adel_hold", inst_ID, 32'habcd0123);
        cyc(0, 0, 0, 0, 1, 32'hbfc00012, 1, 32'h12345678);
        chk("st_adel_inst", inst_ID, 32'h0);
        chk("st_adel_flag", {31'h0, adel_ID}, 32'h1);
        cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
